// File: rtl/adder_result_acc_if.sv
// Handshake bundle between the adder stage, the frame accumulator and its result consumer.
// slave is the accumulator's view; master is the view of whoever drives beats and takes results.
interface adder_result_acc_if #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ACC_WIDTH = 16,
  parameter int unsigned COUNT     = 8
);
  localparam int unsigned CW = $clog2(COUNT + 1);

  logic                 clear;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_co;
  logic [WIDTH-1:0]     in_sum;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_acc;
  logic [CW-1:0]        out_carries;
  logic                 out_ovf;

  modport slave (
    input  clear, in_valid, in_co, in_sum, out_ready,
    output in_ready, out_valid, out_acc, out_carries, out_ovf
  );

  modport master (
    output clear, in_valid, in_co, in_sum, out_ready,
    input  in_ready, out_valid, out_acc, out_carries, out_ovf
  );
endinterface

// File: rtl/adder_result_acc.sv
// Sums COUNT adder beats ({co,sum}) into a frame total with carry count and sticky overflow.
// Result appears one cycle after the last beat and is held (in_ready low) until out_ready.
module adder_result_acc #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ACC_WIDTH = 16,
  parameter int unsigned COUNT     = 8,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  adder_result_acc_if.slave bus
);
  localparam int unsigned CW = $clog2(COUNT + 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t               state_q;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        carries_q, carries_d;
  logic                 ovf_q, ovf_d;
  logic                 in_ready_q;
  logic                 out_valid_q;

  logic [ACC_WIDTH:0]   beat_w;
  logic [ACC_WIDTH:0]   sum_w;
  logic                 accept_w;

  assign accept_w = bus.in_valid & in_ready_q;

  // One extra bit on the adder exposes the overflow as sum_w's MSB.
  always_comb begin
    beat_w    = {{(ACC_WIDTH - WIDTH){1'b0}}, bus.in_co, bus.in_sum};
    sum_w     = {1'b0, acc_q} + beat_w;
    acc_d     = sum_w[ACC_WIDTH-1:0];
    ovf_d     = ovf_q | sum_w[ACC_WIDTH];
    carries_d = carries_q + CW'(bus.in_co);
    cnt_d     = cnt_q + CW'(1);
    if (sum_w[ACC_WIDTH] && SATURATE) begin
      acc_d = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      carries_q   <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (bus.clear) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      carries_q   <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          in_ready_q <= 1'b1;
          if (accept_w) begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            carries_q <= carries_d;
            ovf_q     <= ovf_d;
            if (cnt_d == CW'(COUNT)) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          // Result taken: clear totals now, next beat accepted from the following cycle.
          if (bus.out_ready) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            carries_q   <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_acc     = acc_q;
  assign bus.out_carries = carries_q;
  assign bus.out_ovf     = ovf_q;
endmodule

// File: tb/tb_adder_result_acc.sv
// Directed bench: one 8-bit accumulator plus two 6-bit ones (wrap and saturate) sharing stimulus.
module tb_adder_result_acc;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_co = 1'b0;
  logic [3:0] in_sum = 4'd0;
  logic       out_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_result_acc_if #(.WIDTH(4), .ACC_WIDTH(8), .COUNT(4)) bus8 ();
  adder_result_acc_if #(.WIDTH(4), .ACC_WIDTH(6), .COUNT(4)) bus6w ();
  adder_result_acc_if #(.WIDTH(4), .ACC_WIDTH(6), .COUNT(4)) bus6s ();

  assign bus8.clear  = clear;  assign bus8.in_valid  = in_valid; assign bus8.in_co  = in_co;
  assign bus8.in_sum = in_sum; assign bus8.out_ready = out_ready;
  assign bus6w.clear  = clear;  assign bus6w.in_valid  = in_valid; assign bus6w.in_co  = in_co;
  assign bus6w.in_sum = in_sum; assign bus6w.out_ready = out_ready;
  assign bus6s.clear  = clear;  assign bus6s.in_valid  = in_valid; assign bus6s.in_co  = in_co;
  assign bus6s.in_sum = in_sum; assign bus6s.out_ready = out_ready;

  adder_result_acc #(.WIDTH(4), .ACC_WIDTH(8), .COUNT(4), .SATURATE(1'b0)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8));
  adder_result_acc #(.WIDTH(4), .ACC_WIDTH(6), .COUNT(4), .SATURATE(1'b0)) dut6w (
    .clk(clk), .rst(rst), .bus(bus6w));
  adder_result_acc #(.WIDTH(4), .ACC_WIDTH(6), .COUNT(4), .SATURATE(1'b1)) dut6s (
    .clk(clk), .rst(rst), .bus(bus6s));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic beat(input logic co, input logic [3:0] sum);
    in_valid = 1'b1;
    in_co    = co;
    in_sum   = sum;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_in_ready",  bus8.in_ready, 0);
    check("rst_out_valid", bus8.out_valid, 0);
    check("rst_out_acc",   bus8.out_acc, 0);
    check("rst_carries",   bus8.out_carries, 0);
    check("rst_ovf",       bus8.out_ovf, 0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", bus8.in_ready, 1);

    // Frame 1: 3+5+7+1
    out_ready = 1'b1;
    beat(1'b0, 4'd3); beat(1'b0, 4'd5); beat(1'b0, 4'd7);
    check("f1_no_valid_yet", bus8.out_valid, 0);
    beat(1'b0, 4'd1);
    check("f1_out_valid", bus8.out_valid, 1);
    check("f1_in_ready",  bus8.in_ready, 0);
    check("f1_acc",       bus8.out_acc, 16);
    check("f1_carries",   bus8.out_carries, 0);
    check("f1_ovf",       bus8.out_ovf, 0);
    tick();
    check("f1_hs_valid",    bus8.out_valid, 0);
    check("f1_hs_in_ready", bus8.in_ready, 1);
    check("f1_hs_acc",      bus8.out_acc, 0);

    // Frame 2: 4 x 31, also overflow cases on the 6-bit instances
    for (int i = 0; i < 4; i++) beat(1'b1, 4'd15);
    check("f2_acc",      bus8.out_acc, 124);
    check("f2_carries",  bus8.out_carries, 4);
    check("f2_ovf",      bus8.out_ovf, 0);
    check("wrap_acc",    bus6w.out_acc, 60);
    check("wrap_ovf",    bus6w.out_ovf, 1);
    check("wrap_valid",  bus6w.out_valid, 1);
    check("sat_acc",     bus6s.out_acc, 63);
    check("sat_ovf",     bus6s.out_ovf, 1);
    check("sat_carries", bus6s.out_carries, 4);
    tick();
    check("f2_hs_valid", bus8.out_valid, 0);

    // Frame 3: backpressure with in_valid held high
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(1'b0, 4'd2);
    in_valid = 1'b1; in_co = 1'b0; in_sum = 4'd9;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",    bus8.out_valid, 1);
      check("bp_in_ready", bus8.in_ready, 0);
      check("bp_acc",      bus8.out_acc, 8);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp_hs_valid",    bus8.out_valid, 0);
    check("bp_hs_in_ready", bus8.in_ready, 1);
    check("bp_hs_acc",      bus8.out_acc, 0);

    // Frame 4: clear drops the partial frame and the coincident beat
    out_ready = 1'b0;
    beat(1'b0, 4'd9); beat(1'b0, 4'd9);
    check("clr_partial_acc", bus8.out_acc, 18);
    clear = 1'b1;
    in_valid = 1'b1; in_co = 1'b0; in_sum = 4'd2;
    check("clr_in_ready_same_cycle", bus8.in_ready, 1);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check("clr_acc",      bus8.out_acc, 0);
    check("clr_in_ready", bus8.in_ready, 1);
    for (int i = 0; i < 4; i++) beat(1'b0, 4'd1);
    check("clr_f_valid",   bus8.out_valid, 1);
    check("clr_f_acc",     bus8.out_acc, 4);
    check("clr_f_carries", bus8.out_carries, 0);
    tick();
    check("clr_f_held", bus8.out_valid, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_withdraw_valid",    bus8.out_valid, 0);
    check("clr_withdraw_in_ready", bus8.in_ready, 1);
    check("clr_withdraw_acc",      bus8.out_acc, 0);

    // Async reset mid-frame, asserted between edges
    out_ready = 1'b1;
    beat(1'b0, 4'd1); beat(1'b0, 4'd1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_in_ready",  bus8.in_ready, 0);
    check("arst_out_valid", bus8.out_valid, 0);
    check("arst_acc",       bus8.out_acc, 0);
    tick();
    rst = 1'b0;
    tick();
    check("arst_rel_in_ready", bus8.in_ready, 1);
    for (int i = 0; i < 4; i++) beat(1'b0, 4'd1);
    check("arst_f_valid", bus8.out_valid, 1);
    check("arst_f_acc",   bus8.out_acc, 4);
    tick();
    check("arst_f_hs_valid", bus8.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adder_result_acc.md
Name: adder_result_acc

Overview:
- Downstream consumer of the WIDTH-selected adder stage.
- Takes each adder result beat ({co, sum}) over a valid/ready handshake.
- Accumulates COUNT consecutive beats into one frame total, and counts carry-outs and overflow for the frame.
- Presents the frame result on a valid/ready output and holds it until the result is taken.

Parameters:
- WIDTH, 4, adder sum width; must be >= 1.
- ACC_WIDTH, 16, accumulator width; must be >= WIDTH+1.
- COUNT, 8, beats per frame; must be >= 1.
- SATURATE, 0, 1 = clamp the accumulator on overflow; 0 = wrap modulo 2^ACC_WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous and active-high.
- clear  input  1  synchronous frame abort.
- in_valid  input  1  result beat valid.
- in_ready  output  1  block can accept a beat.
- in_co  input  1  adder carry-out.
- in_sum  input  WIDTH  adder sum.
- out_valid  output  1  frame result valid.
- out_ready  input  1  consumer accepts the result.
- out_acc  output  ACC_WIDTH  frame total.
- out_carries  output  $clog2(COUNT+1)  number of beats in the frame with in_co=1.
- out_ovf  output  1  accumulator overflowed during the frame (sticky per frame).

Behaviour:
- Reset (rst=1, async): state=ACCUM, acc=0, beat counter=0, carries=0, ovf=0, out_valid=0, in_ready=0 while rst is high.
  - All data outputs read 0 after reset.
  - in_ready=1 from the first clock edge after rst deasserts.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept = in_valid & in_ready. On accept:
  - beat value = {in_co, in_sum}, zero-extended to ACC_WIDTH+1.
  - next = acc + beat value.
  - If next >= 2^ACC_WIDTH: ovf<=1; acc <= all-ones if SATURATE=1, else next mod 2^ACC_WIDTH.
  - Otherwise acc <= next.
  - carries += in_co. Beat counter increments.
- ACCUM -> HOLD on the accept that makes the beat counter equal COUNT. out_valid rises the following cycle (1-cycle latency from the last beat).
- Once saturated, acc stays all-ones for the rest of the frame. ovf never clears within a frame.
- In HOLD:
  - out_acc, out_carries and out_ovf are stable. in_valid is ignored and no beats are dropped, because in_ready=0.
- HOLD -> ACCUM on out_valid & out_ready:
  - acc, counter, carries and ovf clear to 0 at that edge.
  - in_ready=1 from the next cycle. No beat is accepted in the same cycle as the output handshake.
- clear (sync, highest priority below rst), in any state:
  - Next state is ACCUM; acc, counter, carries, ovf and out_valid go to 0.
  - A beat presented in the same cycle as clear is discarded; in_ready stays 1 that cycle.
  - clear while out_valid=1 withdraws the result. This is the only case where out_valid falls without out_ready.
- out_* outputs are driven directly from registers, with no combinational input-to-output paths.
- COUNT=1: every accepted beat produces a frame. Maximum throughput is one frame per 2 cycles.
- Counter width is $clog2(COUNT+1). The counter never wraps, because the state changes at COUNT.

Test Plan:
- WIDTH=4, ACC_WIDTH=8, COUNT=4. Beats (co,sum) = (0,3),(0,5),(0,7),(0,1) back-to-back, out_ready=1 -> out_valid one cycle after the 4th beat; out_acc=16, out_carries=0, out_ovf=0. in_ready returns one cycle after the output handshake.
- Same config, 4 beats of (1,15) -> out_acc=124, out_carries=4, out_ovf=0.
- ACC_WIDTH=6, 4 beats of (1,15):
  - SATURATE=0 -> out_acc=60, out_ovf=1.
  - SATURATE=1 -> out_acc=63, out_ovf=1.
- Backpressure: frame completes with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 and outputs unchanged throughout. Raising out_ready then gives one handshake, and the next frame starts from acc=0.
- Clear: 2 beats of (0,9), then clear together with a (0,2) beat, then 4 beats of (0,1) -> result out_acc=4, out_carries=0. The (0,2) beat is not counted.
- Async reset: assert rst mid-frame, between clock edges -> out_valid=0 and in_ready=0 immediately. After release, a fresh 4-beat frame of (0,1) gives out_acc=4.
